// File: rtl/sio_responder.sv
// Device end of the EPL serial GPIO chain: WIDTH-bit shift-register expander oversampled in csi_MCLK_clk.
// Optional input-change interrupt is built when SIO_RESP_INT_EN is defined; otherwise EPL_INT is tied low.
module sio_responder #(
    parameter int               WIDTH       = 32,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] OUT_INIT    = '0
) (
    input  logic             csi_MCLK_clk,
    input  logic             rsi_MRST_reset_n,
    input  logic             EPL_SCLK,
    input  logic             EPL_SLE,
    input  logic             EPL_SDI,
    output logic             EPL_SDO,
    output logic             EPL_INT,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] pin_out,
    output logic             frame_done,
    output logic [7:0]       bit_count
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_SHIFT   = 2'd2;
    localparam logic [1:0] S_UPDATE  = 2'd3;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sle_sync_q, sdi_sync_q;
    logic [WIDTH-1:0]       pin_sync_q [SYNC_STAGES];
    logic                   sclk_dly_q, sle_dly_q;

    logic                   sclk_s, sle_s, sdi_s;
    logic [WIDTH-1:0]       pin_s;
    logic                   sclk_fall, sle_rise, sle_fall;

    logic [1:0]             state_q, state_d;
    logic [WIDTH-1:0]       shreg_q, shreg_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [WIDTH-1:0]       pin_out_q, pin_out_d;
    logic [7:0]             bit_count_q, bit_count_d;
    logic                   frame_done_q, frame_done_d;

    // NOTE: the SLE chain and its delay flop reset high so an SLE already high at reset release is not a rise.
    always_ff @(posedge csi_MCLK_clk) begin
        if (!rsi_MRST_reset_n) begin
            sclk_sync_q <= '0;
            sle_sync_q  <= '1;
            sdi_sync_q  <= '0;
            sclk_dly_q  <= 1'b0;
            sle_dly_q   <= 1'b1;
            for (int i = 0; i < SYNC_STAGES; i++) pin_sync_q[i] <= '0;
        end else begin
            sclk_sync_q   <= {sclk_sync_q[SYNC_STAGES-2:0], EPL_SCLK};
            sle_sync_q    <= {sle_sync_q[SYNC_STAGES-2:0], EPL_SLE};
            sdi_sync_q    <= {sdi_sync_q[SYNC_STAGES-2:0], EPL_SDI};
            sclk_dly_q    <= sclk_s;
            sle_dly_q     <= sle_s;
            pin_sync_q[0] <= pin_in;
            for (int i = 1; i < SYNC_STAGES; i++) pin_sync_q[i] <= pin_sync_q[i-1];
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign sle_s     = sle_sync_q[SYNC_STAGES-1];
    assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
    assign pin_s     = pin_sync_q[SYNC_STAGES-1];
    assign sclk_fall = sclk_dly_q & ~sclk_s;
    assign sle_rise  = sle_s & ~sle_dly_q;
    assign sle_fall  = ~sle_s & sle_dly_q;

    // NOTE: every next-state signal takes its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        pin_out_d    = pin_out_q;
        bit_count_d  = bit_count_q;
        frame_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sle_rise) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                shreg_d = pin_s;
                cnt_d   = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                // End of frame outranks a simultaneous SCLK fall; that shift is dropped.
                if (sle_fall) begin
                    state_d = S_UPDATE;
                end else if (sclk_fall) begin
                    shreg_d = {shreg_q[WIDTH-2:0], sdi_s};
                    if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
                end
            end
            S_UPDATE: begin
                bit_count_d  = cnt_q;
                frame_done_d = 1'b1;
                if ({24'd0, cnt_q} >= 32'(WIDTH)) pin_out_d = shreg_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge csi_MCLK_clk) begin
        if (!rsi_MRST_reset_n) begin
            state_q      <= S_IDLE;
            shreg_q      <= '0;
            cnt_q        <= '0;
            pin_out_q    <= OUT_INIT;
            bit_count_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            pin_out_q    <= pin_out_d;
            bit_count_q  <= bit_count_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign EPL_SDO    = shreg_q[WIDTH-1];
    assign pin_out    = pin_out_q;
    assign bit_count  = bit_count_q;
    assign frame_done = frame_done_q;

`ifdef SIO_RESP_INT_EN
    logic [WIDTH-1:0] snap_q;
    logic             int_q;

    // CAPTURE both clears the flag and reloads the snapshot, so a change landing in that cycle is absorbed.
    always_ff @(posedge csi_MCLK_clk) begin
        if (!rsi_MRST_reset_n) begin
            snap_q <= '0;
            int_q  <= 1'b0;
        end else if (state_q == S_CAPTURE) begin
            snap_q <= pin_s;
            int_q  <= 1'b0;
        end else if (pin_s != snap_q) begin
            int_q  <= 1'b1;
        end
    end

    assign EPL_INT = int_q;
`else
    assign EPL_INT = 1'b0;
`endif

endmodule

// File: tb/tb_sio_responder.sv
// Directed bench for sio_responder: a master task drives EPL frames, expected frame results go to a
// scoreboard queue and a monitor pops them on each frame_done pulse.
module tb_sio_responder;

    localparam int WIDTH = 32;
    localparam int SYNC  = 2;
    localparam int HALF  = 16;
`ifdef SIO_RESP_INT_EN
    localparam logic INT_EN = 1'b1;
`else
    localparam logic INT_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pin;
        logic [7:0]  cnt;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              EPL_SCLK, EPL_SLE, EPL_SDI;
    logic              EPL_SDO, EPL_INT;
    logic [WIDTH-1:0]  pin_in, pin_out;
    logic              frame_done;
    logic [7:0]        bit_count;

    exp_t              sb_q[$];
    int                n_checks = 0;
    int                n_fail   = 0;

    always #5 clk = ~clk;

    sio_responder #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .OUT_INIT('0)) dut (
        .csi_MCLK_clk     (clk),
        .rsi_MRST_reset_n (rst_n),
        .EPL_SCLK         (EPL_SCLK),
        .EPL_SLE          (EPL_SLE),
        .EPL_SDI          (EPL_SDI),
        .EPL_SDO          (EPL_SDO),
        .EPL_INT          (EPL_INT),
        .pin_in           (pin_in),
        .pin_out          (pin_out),
        .frame_done       (frame_done),
        .bit_count        (bit_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Master frame: SDO sampled and SDI changed on SCLK rise; device shifts on SCLK fall.
    task automatic frame(input int nbits, input logic [127:0] sdi, input logic [31:0] pin,
                         input bit close, input logic [31:0] exp_pin, input logic [7:0] exp_cnt);
        logic exp_sdo;
        exp_t e;
        pin_in = pin;
        tick(8);
        EPL_SCLK = 1'b0;
        EPL_SLE  = 1'b1;
        tick(HALF);
        for (int i = 0; i < nbits; i++) begin
            EPL_SCLK = 1'b1;
            exp_sdo  = (i < 32) ? pin[31-i] : sdi[nbits-1-(i-32)];
            check("sdo_bit", 64'(EPL_SDO), 64'(exp_sdo));
            EPL_SDI  = sdi[nbits-1-i];
            tick(HALF);
            EPL_SCLK = 1'b0;
            tick(HALF);
        end
        if (close) begin
            e.pin = exp_pin;
            e.cnt = exp_cnt;
            sb_q.push_back(e);
            EPL_SLE = 1'b0;
            tick(24);
            check("frame_done_seen", 64'(sb_q.size()), 64'd0);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_frame_done", 64'(frame_done), 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("pin_out", 64'(pin_out), 64'(e.pin));
                    check("bit_count", 64'(bit_count), 64'(e.cnt));
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: time limit reached at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [31:0] pin_v;

        // Reset with random pins
        rst_n    = 1'b0;
        EPL_SCLK = 1'b0;
        EPL_SLE  = 1'b0;
        EPL_SDI  = 1'($urandom);
        pin_in   = $urandom;
        tick(4);
        check("rst_pin_out", 64'(pin_out), 64'd0);
        check("rst_sdo", 64'(EPL_SDO), 64'd0);
        check("rst_int", 64'(EPL_INT), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_bit_count", 64'(bit_count), 64'd0);
        rst_n = 1'b1;
        tick(4);

        // Full 32-bit frame
        frame(32, 128'hA5A51234, 32'hDEADBEEF, 1'b1, 32'hA5A51234, 8'd32);

        // Short frame leaves pin_out alone
        frame(10, 128'h2AA, 32'hDEADBEEF, 1'b1, 32'hA5A51234, 8'd10);

        // 66-bit daisy-chain frame: pin_out keeps the last 32 SDI bits
        frame(66, 128'h2_0123_4567_89AB_CDEF, 32'h13579BDF, 1'b1, 32'h89ABCDEF, 8'd66);

        // Reset after 16 bits with SLE still high; the trailing SLE fall must not end a frame
        frame(16, 128'h5A5A, 32'hCAFEF00D, 1'b0, 32'h0, 8'd0);
        rst_n = 1'b0;
        tick(2);
        check("midrst_pin_out", 64'(pin_out), 64'd0);
        check("midrst_bit_count", 64'(bit_count), 64'd0);
        check("midrst_sdo", 64'(EPL_SDO), 64'd0);
        rst_n = 1'b1;
        tick(20);
        EPL_SLE = 1'b0;
        tick(40);
        frame(32, 128'h00FF00FF, 32'hCAFEF00D, 1'b1, 32'h00FF00FF, 8'd32);

        // Input-change interrupt
        check("int_idle", 64'(EPL_INT), 64'd0);
        pin_v    = pin_in;
        pin_v[3] = ~pin_v[3];
        pin_in   = pin_v;
        tick(SYNC + 2);
        check("int_after_change", 64'(EPL_INT), 64'(INT_EN));
        frame(32, 128'h12345678, pin_v, 1'b1, 32'h12345678, 8'd32);
        check("int_cleared", 64'(EPL_INT), 64'd0);

        tick(10);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
